// File: rtl/apb_pkg.sv
// Shared APB definitions: state encodings, default widths and the
// address field layout used by both the master and its completers.
package apb_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_SLAVE_NUM  = 2;
    localparam int DEF_REG_NUM    = 8;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        M_IDLE   = 2'd0,
        M_SETUP  = 2'd1,
        M_ACCESS = 2'd2
    } mst_state_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } slv_state_e;

    function automatic int data_byte_num(input int dw);
        return dw / 8;
    endfunction

    // Slave-select lives in the top SLAVE_NUM bits; the rest is byte offset.
    function automatic int offset_msb(input int aw, input int sn);
        return aw - sn - 1;
    endfunction

    function automatic int sel_lsb(input int aw, input int sn);
        return aw - sn;
    endfunction

endpackage

// File: rtl/apb_strb_reg.sv
// One DATA_WIDTH register with an independent write enable per byte
// lane and asynchronous active-low reset.
module apb_strb_reg
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          we,
    input  logic [DATA_WIDTH/8-1:0]       strb,
    input  logic [DATA_WIDTH-1:0]         wdata,
    output logic [DATA_WIDTH-1:0]         q
);

    localparam int BYTE_NUM = data_byte_num(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] q_q;
    logic [DATA_WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (we) begin
            for (int k = 0; k < BYTE_NUM; k++) begin
                if (strb[k]) begin
                    q_d[k*8 +: 8] = wdata[k*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer holding REG_NUM byte-strobed registers, with a fixed
// number of wait states and PSLVERR on unaligned or out-of-range access.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int SLAVE_NUM   = DEF_SLAVE_NUM,
    parameter int REG_NUM     = DEF_REG_NUM,
    parameter int WAIT_STATES = 0
) (
    input  logic                          PCLK,
    input  logic                          PRESET_n,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic                          PWRITE,
    input  logic [ADDR_WIDTH-1:0]         PADDR,
    input  logic [DATA_WIDTH-1:0]         PWDATA,
    input  logic [DATA_WIDTH/8-1:0]       PSTRB,
    output logic                          PREADY,
    output logic [DATA_WIDTH-1:0]         PRDATA,
    output logic                          PSLVERR,
    output logic [REG_NUM*DATA_WIDTH-1:0] reg_out
);

    localparam int BYTE_NUM = data_byte_num(DATA_WIDTH);
    localparam int OFF_MSB  = offset_msb(ADDR_WIDTH, SLAVE_NUM);
    localparam int SEL_LSB  = sel_lsb(ADDR_WIDTH, SLAVE_NUM);
    localparam int OFF_W    = OFF_MSB + 1;
    localparam int SHIFT    = $clog2(BYTE_NUM);
    localparam int IDX_W    = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

    slv_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  err_q, err_d;
    logic                  wr_q, wr_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic [OFF_W-1:0]      offset;
    logic [OFF_W-1:0]      word_idx;
    logic                  addr_err;
    logic                  setup;
    logic                  commit;
    logic                  unused_sel;
    logic [DATA_WIDTH-1:0] regs [REG_NUM];

    assign offset     = PADDR[OFF_MSB:0];
    assign word_idx   = offset >> SHIFT;
    assign addr_err   = ((offset & OFF_W'(BYTE_NUM - 1)) != '0)
                      || (word_idx >= OFF_W'(REG_NUM));
    assign setup      = PSEL && !PENABLE;
    assign unused_sel = ^PADDR[ADDR_WIDTH-1:SEL_LSB];

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        wr_d    = wr_q;
        unique case (state_q)
            S_IDLE: begin
                if (setup) begin
                    idx_d   = word_idx[IDX_W-1:0];
                    err_d   = addr_err;
                    wr_d    = PWRITE;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? S_READY : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // A dropped select abandons the transfer silently.
                if (!PSEL) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        if (state_q != S_READY && state_d == S_READY) begin
            pready_d  = 1'b1;
            pslverr_d = err_d;
            if (!err_d && !wr_d) begin
                prdata_d = regs[idx_d];
            end
        end
    end

    assign commit = (state_q == S_READY) && PSEL && PENABLE
                 && PWRITE && wr_q && !err_q;

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            wr_q      <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            wr_q      <= wr_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign PRDATA  = prdata_q;

    for (genvar i = 0; i < REG_NUM; i++) begin : g_reg
        logic we;
        assign we = commit && (idx_q == IDX_W'(i));

        apb_strb_reg #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_reg (
            .clk   (PCLK),
            .rst_n (PRESET_n),
            .we    (we),
            .strb  (PSTRB),
            .wdata (PWDATA),
            .q     (regs[i])
        );

        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: a zero-wait and a three-wait instance
// share one APB bus, checked against a register model and scoreboard.
module tb_apb_slave_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel0 = 1'b0;
    logic        psel3 = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;

    logic        pready0, pready3;
    logic        pslverr0, pslverr3;
    logic [31:0] prdata0, prdata3;
    logic [255:0] regout0, regout3;

    int checks = 0;
    int errors = 0;

    logic [31:0] m0 [8];
    logic [31:0] m3 [8];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t exp_q [$];

    always #5 clk = ~clk;

    apb_slave_regfile #(.WAIT_STATES(0)) u0 (
        .PCLK(clk), .PRESET_n(rst_n), .PSEL(psel0), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0),
        .reg_out(regout0)
    );

    apb_slave_regfile #(.WAIT_STATES(3)) u3 (
        .PCLK(clk), .PRESET_n(rst_n), .PSEL(psel3), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PREADY(pready3), .PRDATA(prdata3), .PSLVERR(pslverr3),
        .reg_out(regout3)
    );

    function automatic logic rdy(input int d);
        return (d == 0) ? pready0 : pready3;
    endfunction

    function automatic logic [31:0] rdat(input int d);
        return (d == 0) ? prdata0 : prdata3;
    endfunction

    function automatic logic serr(input int d);
        return (d == 0) ? pslverr0 : pslverr3;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            m0[i] = '0;
            m3[i] = '0;
        end
    endtask

    task automatic bus_idle();
        @(posedge clk); #1;
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb);
        exp_t e;
        exp_t got;
        int idx;
        int n;
        logic err;
        logic [31:0] cur;
        idx = int'(addr[29:2]);
        err = (addr[1:0] != 2'b00) || (addr[29:2] >= 28'd8);
        cur = '0;
        if (!err) cur = (d == 0) ? m0[idx] : m3[idx];
        e.err   = err;
        e.rdata = (wr || err) ? 32'h0 : cur;
        e.lat   = (d == 0) ? 1 : 4;
        if (wr && !err) begin
            for (int k = 0; k < 4; k++)
                if (strb[k]) cur[k*8 +: 8] = data[k*8 +: 8];
            if (d == 0) m0[idx] = cur; else m3[idx] = cur;
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        paddr = addr; pwrite = wr; pwdata = data; pstrb = strb;
        psel0 = (d == 0); psel3 = (d == 3); penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        n = 1;
        while (!rdy(d) && n < 40) begin
            checks++;
            if (rdat(d) !== 32'h0 || serr(d) !== 1'b0) begin
                errors++;
                $display("FAIL wait_outputs dut%0d cyc%0d prdata=%h pslverr=%b required 0/0",
                         d, n, rdat(d), serr(d));
            end
            @(posedge clk); #1;
            n++;
        end
        got = exp_q.pop_front();
        checks++;
        if (!rdy(d)) begin
            errors++;
            $display("FAIL pready_timeout dut%0d addr=%h", d, addr);
        end else begin
            checks++;
            if (n !== got.lat) begin
                errors++;
                $display("FAIL latency dut%0d addr=%h got %0d required %0d",
                         d, addr, n, got.lat);
            end
            checks++;
            if (serr(d) !== got.err) begin
                errors++;
                $display("FAIL pslverr dut%0d addr=%h got %b required %b",
                         d, addr, serr(d), got.err);
            end
            checks++;
            if (rdat(d) !== got.rdata) begin
                errors++;
                $display("FAIL prdata dut%0d addr=%h got %h required %h",
                         d, addr, rdat(d), got.rdata);
            end
        end
    endtask

    task automatic check_image(input int d);
        logic [31:0] w;
        for (int i = 0; i < 8; i++) begin
            w = (d == 0) ? regout0[i*32 +: 32] : regout3[i*32 +: 32];
            checks++;
            if (w !== ((d == 0) ? m0[i] : m3[i])) begin
                errors++;
                $display("FAIL reg_out dut%0d word%0d got %h required %h",
                         d, i, w, (d == 0) ? m0[i] : m3[i]);
            end
        end
    endtask

    task automatic test_reset();
        clear_model();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({pready0, pslverr0, prdata0, pready3, pslverr3, prdata3} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b%b%h %b%b%h required all 0",
                     pready0, pslverr0, prdata0, pready3, pslverr3, prdata3);
        end
        checks++;
        if (regout0 !== '0 || regout3 !== '0) begin
            errors++;
            $display("FAIL reset_reg_out got %h / %h required 0", regout0, regout3);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero_wait_write();
        xfer(0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
        bus_idle();
        xfer(0, 1'b0, 32'h4, 32'h0, 4'h0);
        bus_idle();
        check_image(0);
    endtask

    task automatic test_strobe();
        xfer(0, 1'b1, 32'h4, 32'h11223344, 4'b0101);
        bus_idle();
        xfer(0, 1'b0, 32'h4, 32'h0, 4'h0);
        bus_idle();
        checks++;
        if (m0[1] !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL strobe_model got %h required DE22BE44", m0[1]);
        end
        xfer(0, 1'b1, 32'h8, 32'hCAFEF00D, 4'h0);
        bus_idle();
        check_image(0);
    endtask

    task automatic test_wait_states();
        xfer(3, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
        bus_idle();
        xfer(3, 1'b0, 32'h4, 32'h0, 4'hF);
        bus_idle();
        check_image(3);
    endtask

    task automatic test_errors();
        xfer(0, 1'b1, 32'h20, 32'h12345678, 4'hF);
        bus_idle();
        xfer(0, 1'b1, 32'h6, 32'h87654321, 4'hF);
        bus_idle();
        xfer(0, 1'b0, 32'h5, 32'h0, 4'h0);
        bus_idle();
        xfer(3, 1'b1, 32'h40, 32'h5555AAAA, 4'hF);
        bus_idle();
        check_image(0);
        check_image(3);
    endtask

    task automatic test_back_to_back();
        xfer(0, 1'b1, 32'h0, 32'hA5A5_0F0F, 4'hF);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0);
        xfer(0, 1'b1, 32'h1C, 32'h0BAD_F00D, 4'hF);
        xfer(0, 1'b0, 32'h1C, 32'h0, 4'h0);
        bus_idle();
        check_image(0);
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        paddr = 32'h8; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
        psel3 = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (regout0 !== '0 || regout3 !== '0) begin
            errors++;
            $display("FAIL async_reg_out got %h / %h required 0", regout0, regout3);
        end
        checks++;
        if ({pready3, pslverr3, prdata3, pready0, prdata0} !== '0) begin
            errors++;
            $display("FAIL async_outputs got %b%b%h %b%h required 0",
                     pready3, pslverr3, prdata3, pready0, prdata0);
        end
        #1;
        psel3 = 1'b0; penable = 1'b0;
        rst_n = 1'b1;
        clear_model();
        xfer(3, 1'b0, 32'h8, 32'h0, 4'h0);
        bus_idle();
        xfer(3, 1'b1, 32'h8, 32'h1357_9BDF, 4'hF);
        bus_idle();
        xfer(3, 1'b0, 32'h8, 32'h0, 4'h0);
        bus_idle();
        xfer(0, 1'b0, 32'h4, 32'h0, 4'h0);
        bus_idle();
        check_image(3);
        check_image(0);
    endtask

    initial begin
        test_reset();
        test_zero_wait_write();
        test_strobe();
        test_wait_states();
        test_errors();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB completer (slave) that sits on one PSEL line of the team's APB master.
- Holds a bank of REG_NUM byte-strobed read/write registers.
- Inserts a programmable number of wait states and flags illegal accesses with PSLVERR.
- Register contents are also exported flat for use by downstream logic.

Parameters:
DATA_WIDTH, 32, data bus width; must be a multiple of 8.
ADDR_WIDTH, 32, width of PADDR.
SLAVE_NUM, 2, number of PADDR MSBs that carry slave-select; ignored by this block.
REG_NUM, 8, number of DATA_WIDTH registers; range 1..256.
WAIT_STATES, 0, access-phase cycles with PREADY low before completion; range 0..15.

Ports:
PCLK  in  1  system clock; only clock.
PRESET_n  in  1  asynchronous active-low reset.
PSEL  in  1  this slave's select bit, already decoded by the master.
PENABLE  in  1  access-phase indicator.
PWRITE  in  1  1 = write, 0 = read.
PADDR  in  ADDR_WIDTH  byte address.
PWDATA  in  DATA_WIDTH  write data.
PSTRB  in  DATA_WIDTH/8  write byte strobes.
PREADY  out  1  transfer completion.
PRDATA  out  DATA_WIDTH  read data.
PSLVERR  out  1  transfer error; valid only while PREADY=1.
reg_out  out  REG_NUM*DATA_WIDTH  flat register image; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset: one clock PCLK; async active-low PRESET_n. Asserting PRESET_n=0 forces the following immediately, independent of PCLK:
  - FSM to IDLE, wait counter to 0.
  - PREADY=0, PRDATA=0, PSLVERR=0.
  - All registers to 0, so reg_out=0.
  - Reset mid-transfer aborts it: no partial write, and the next transfer starts from IDLE.
- Address decode:
  - offset = PADDR[ADDR_WIDTH-SLAVE_NUM-1:0].
  - Word index = offset >> log2(DATA_WIDTH/8).
  - Error when offset is unaligned (low byte bits non-zero) or when index >= REG_NUM.
  - Decode is latched at the setup cycle.
- FSM, states IDLE, WAIT, READY:
  - IDLE: on PSEL=1 and PENABLE=0 (setup), latch index, error flag and PWRITE; load counter = WAIT_STATES. Go to READY if WAIT_STATES=0, otherwise to WAIT.
  - WAIT: PREADY=0. Decrement the counter each cycle; when counter=1, go to READY.
  - WAIT abort: if PSEL drops to 0, return to IDLE with no write and no response.
  - READY: PREADY=1 for exactly one cycle, then unconditionally IDLE. A back-to-back setup on the following cycle is accepted by IDLE.
- Latency:
  - PREADY rises on access cycle number WAIT_STATES+1.
  - Zero-wait transfers complete in 2 PCLK (setup + access).
  - Minimum inter-transfer spacing is 2 cycles, which matches the master's ACCESS->SETUP path.
- Outputs are registered: PREADY, PRDATA and PSLVERR are all registered, set on entry to READY.
- Write:
  - Commits at the PCLK edge ending the READY cycle, only when PSEL=1, PENABLE=1, PWRITE=1 and no error.
  - Byte k updates only if PSTRB[k]=1. PSTRB=0 means no change, and this is not an error.
- Read:
  - PRDATA = selected register, loaded on entry to READY.
  - PRDATA=0 in all other cycles and on error reads.
  - PSTRB is ignored on reads.
- Errors:
  - PSLVERR=1 only in the READY cycle of an erroring transfer.
  - Registers are unchanged on an erroring write.
- PWDATA and PSTRB are sampled in the READY cycle, not at setup.
- PENABLE=1 while in IDLE is a protocol violation: ignored, no response.

Decomposition:
- Shared package apb_pkg:
  - State encoding (IDLE/SETUP/ACCESS for the master, IDLE/WAIT/READY for the slave).
  - DATA_BYTE_NUM derivation.
  - Default widths.
  - Address field positions: slave-select in the MSBs, byte offset in the low bits.
- One natural sub-module, apb_strb_reg: a single DATA_WIDTH register with per-byte write enables and async reset. Instantiate it REG_NUM times via generate.
- The FSM, decode and wait counter stay in the top module.

Test Plan:
1. Reset then zero-wait write: PADDR=0x0000_0004, PWDATA=0xDEADBEEF, PSTRB=4'hF -> PREADY=1 on the first access cycle, PSLVERR=0; a later read of 0x4 returns 0xDEADBEEF and reg_out word1=0xDEADBEEF.
2. Strobed write: PSTRB=4'b0101, PWDATA=0x11223344 to a register holding 0xDEADBEEF -> read returns 0xDE22BE44.
3. WAIT_STATES=3: read of 0x4 -> PREADY low for 3 access cycles and high on the 4th; PRDATA=0 until then, then 0xDEADBEEF.
4. Errors: write to 0x20 (index 8, REG_NUM=8), and a separate write to 0x6 (unaligned) -> PSLVERR=1 with PREADY=1 on each; all registers unchanged; PRDATA=0.
5. Back-to-back write 0x0 then read 0x0 with no idle cycle between -> each completes in 2 cycles; the read returns the just-written value.
6. PRESET_n pulsed low between PCLK edges during a WAIT-state write -> outputs clear immediately, with no clock edge needed; registers read 0; the next transfer completes normally.
